ddfs_sample_buffer: RTL and testbench

DDFS_SAMPLE_BUFFER -- requirements
Module: ddfs_sample_buffer

---
 rtl/ddfs_sample_buffer.sv | 152 +++++++++++++++
 tb/tb_ddfs_sample_buffer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddfs_sample_buffer.sv
// ddfs_sample_buffer: decimating capture buffer for DDFS sine/triangle samples.
// An arm request starts a capture of DEPTH write slots. There is one slot every
// DECIM cycles. The slots are written into a first-word-fall-through FIFO that
// the consumer may drain at any time.
// Optional build macro: DDFS_SAMPLE_TRIGGER_EN adds an ARMED state. In that
// state the capture waits for a rising zero crossing of sine_in.
module ddfs_sample_buffer #(
  parameter int DEPTH = 16,
  parameter int DECIM = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [15:0]     sine_in,
  input  logic signed [16:0]     tri_in,
  input  logic                   arm,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [32:0]            out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [CW-1:0] SLOT_LAST = CW'(DEPTH - 1);

`ifdef DDFS_SAMPLE_TRIGGER_EN
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
`endif

  state_t          state;
  logic [DW-1:0]   dec_cnt;
  logic [CW-1:0]   slot_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [32:0]     mem [DEPTH];
  logic            trigger;
  logic            write_slot;
  logic            pop;
  logic            push_ok;

`ifdef DDFS_SAMPLE_TRIGGER_EN
  logic            prev_neg;

  // Remember the sign of the previous sine sample for zero-crossing detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_neg <= 1'b0;
    else       prev_neg <= sine_in[15];
  end
`endif

  // Decode write slots: decimation phase zero in CAPTURE, or the trigger cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    trigger = 1'b0;
`ifdef DDFS_SAMPLE_TRIGGER_EN
    trigger = (state == ARMED) && prev_neg && !sine_in[15];
`endif
    write_slot = ((state == CAPTURE) && (dec_cnt == '0)) || trigger;
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts the sample if the same cycle frees an entry.
  assign push_ok   = write_slot && ((count != FULL) || pop);
  assign busy      = (state != IDLE);

  // Control FSM: state sequencing, decimation and slot counters, done and overflow.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state    <= IDLE;
      dec_cnt  <= '0;
      slot_cnt <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (write_slot && !push_ok) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (arm) begin
            overflow <= 1'b0;
            dec_cnt  <= '0;
            slot_cnt <= '0;
`ifdef DDFS_SAMPLE_TRIGGER_EN
            state    <= ARMED;
`else
            state    <= CAPTURE;
`endif
          end
        end
`ifdef DDFS_SAMPLE_TRIGGER_EN
        ARMED: begin
          // The trigger cycle is slot 1, so decimation resumes one phase later.
          if (trigger) begin
            state    <= CAPTURE;
            slot_cnt <= CW'(1);
            dec_cnt  <= DW'(1 % DECIM);
          end
        end
`endif
        CAPTURE: begin
          dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
          if (write_slot) begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_cnt == SLOT_LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (count == '0) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Sample storage. Its contents are only observed behind out_valid.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset; occupancy alone decides what is valid.
    if (push_ok) mem[wr_ptr] <= {tri_in, sine_in};
  end

endmodule

// File: tb/tb_ddfs_sample_buffer.sv
// Self-checking bench for ddfs_sample_buffer. Three instances run side by side:
// 16/4, 16/1 and 4/1 (DEPTH/DECIM). Each cycle a queue-based reference model
// predicts the outputs. Directed sequences also check the documented corner cases.
`timescale 1ns/1ps
module tb_ddfs_sample_buffer;

  localparam int NI = 3;
`ifdef DDFS_SAMPLE_TRIGGER_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  typedef enum int {M_IDLE, M_ARMED, M_CAP, M_DRAIN} mstate_t;

  typedef struct {
    bit arm;
    bit rdy;
    int n;
    int e_count;
    bit e_busy;
    bit e_done;
    bit e_valid;
    int e_sine;
  } row_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]      rst, arm_s, rdy;
  logic signed [15:0] sine_v;
  logic signed [16:0] tri_v;
  logic [NI-1:0]      dv, db, dn, dof;
  logic [32:0]        dd [NI];
  logic [4:0]         c0, c1;
  logic [2:0]         c2;

  ddfs_sample_buffer #(.DEPTH(16), .DECIM(4)) u_d16_m4 (
    .clk(clk), .reset(rst[0]), .sine_in(sine_v), .tri_in(tri_v), .arm(arm_s[0]),
    .out_ready(rdy[0]), .out_valid(dv[0]), .out_data(dd[0]), .count(c0),
    .busy(db[0]), .done(dn[0]), .overflow(dof[0]));

  ddfs_sample_buffer #(.DEPTH(16), .DECIM(1)) u_d16_m1 (
    .clk(clk), .reset(rst[1]), .sine_in(sine_v), .tri_in(tri_v), .arm(arm_s[1]),
    .out_ready(rdy[1]), .out_valid(dv[1]), .out_data(dd[1]), .count(c1),
    .busy(db[1]), .done(dn[1]), .overflow(dof[1]));

  ddfs_sample_buffer #(.DEPTH(4), .DECIM(1)) u_d4_m1 (
    .clk(clk), .reset(rst[2]), .sine_in(sine_v), .tri_in(tri_v), .arm(arm_s[2]),
    .out_ready(rdy[2]), .out_valid(dv[2]), .out_data(dd[2]), .count(c2),
    .busy(db[2]), .done(dn[2]), .overflow(dof[2]));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model state, one slot per instance.
  mstate_t     m_state [NI];
  int          m_k     [NI];
  int          m_slots [NI];
  int          m_head  [NI];
  int          m_size  [NI];
  int          m_prev  [NI];
  bit          m_done  [NI];
  bit          m_ovf   [NI];
  logic [32:0] m_buf   [NI][256];

  // Observation logs taken from the DUT.
  logic [32:0] plog  [NI][512];
  int          plen  [NI];
  int          ndone [NI];
  int          maxc;

  function automatic int dep(input int i);
    return (i == 2) ? 4 : 16;
  endfunction

  function automatic int dec(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int dut_count(input int i);
    case (i)
      0:       return int'(c0);
      1:       return int'(c1);
      default: return int'(c2);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // One clock edge of the model, written from the capture rules rather than the RTL structure.
  task automatic model_step(input int i);
    bit          pop, push;
    int          s0;
    logic [32:0] d;
    if (rst[i]) begin
      m_state[i] = M_IDLE; m_k[i] = 0; m_slots[i] = 0; m_head[i] = 0;
      m_size[i] = 0; m_prev[i] = 0; m_done[i] = 1'b0; m_ovf[i] = 1'b0;
      return;
    end
    d          = {tri_v, sine_v};
    s0         = m_size[i];
    pop        = (s0 != 0) && rdy[i];
    push       = 1'b0;
    m_done[i]  = 1'b0;
    case (m_state[i])
      M_IDLE: if (arm_s[i]) begin
        m_ovf[i] = 1'b0; m_k[i] = 0; m_slots[i] = 0;
        m_state[i] = TRIG ? M_ARMED : M_CAP;
      end
      M_ARMED: if (m_prev[i] < 0 && sine_v >= 0) begin
        push = 1'b1; m_slots[i] = 1; m_k[i] = 1; m_state[i] = M_CAP;
      end
      M_CAP: begin
        if (m_k[i] % dec(i) == 0) begin
          push = 1'b1;
          m_slots[i]++;
        end
        m_k[i]++;
        if (m_slots[i] == dep(i)) m_state[i] = M_DRAIN;
      end
      M_DRAIN: if (s0 == 0) begin
        m_state[i] = M_IDLE; m_done[i] = 1'b1;
      end
      default: ;
    endcase
    if (pop) begin
      m_head[i] = (m_head[i] + 1) % 256;
      m_size[i]--;
    end
    if (push) begin
      if (s0 < dep(i) || pop) begin
        m_buf[i][(m_head[i] + m_size[i]) % 256] = d;
        m_size[i]++;
      end else begin
        m_ovf[i] = 1'b1;
      end
    end
    m_prev[i] = int'(sine_v);
  endtask

  function automatic logic [63:0] model_vec(input int i);
    logic [32:0] d;
    d = (m_size[i] != 0) ? m_buf[i][m_head[i]] : 33'd0;
    return {18'd0, (m_size[i] != 0), d, 9'(m_size[i]), (m_state[i] != M_IDLE), m_done[i], m_ovf[i]};
  endfunction

  function automatic logic [63:0] dut_vec(input int i);
    return {18'd0, dv[i], (dv[i] ? dd[i] : 33'd0), 9'(dut_count(i)), db[i], dn[i], dof[i]};
  endfunction

  // Advance one clock: log pops, step the model, sample at the falling edge, compare.
  task automatic tick();
    for (int i = 0; i < NI; i++) begin
      if (!rst[i] && dv[i] && rdy[i] && plen[i] < 512) begin
        plog[i][plen[i]] = dd[i];
        plen[i]++;
      end
    end
    for (int i = 0; i < NI; i++) model_step(i);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("model inst%0d cyc%0d", i, cyc), dut_vec(i), model_vec(i));
      if (dn[i]) ndone[i]++;
    end
    if (dut_count(1) > maxc) maxc = dut_count(1);
  endtask

  task automatic set_sine(input int v);
    sine_v = 16'(v);
    tri_v  = 17'(-v);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NI; i++) begin
      plen[i]  = 0;
      ndone[i] = 0;
    end
    maxc = 0;
  endtask

  task automatic reset_all();
    rst   = '1;
    arm_s = '0;
    tick();
    rst   = '0;
    clear_logs();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  row_t rows [9];

  initial begin
    rst = '1; arm_s = '0; rdy = '0;
    sine_v = '0; tri_v = '0;
    clear_logs();

    // Reset state of all instances.
    tick();
    check("reset state", {dv, db, dn, dof, c0, c1, c2}, 64'd0);
    rst = '0;

    // Ramp capture, DECIM=4, always ready: slots at cycles 1,5,...,61.
    reset_all();
    rdy = '1;
    for (int c = 0; c < 70; c++) begin
      set_sine(c);
      arm_s[0] = (c == 0);
      tick();
    end
    arm_s = '0;
    check("d4 sample count", plen[0], 16);
    for (int k = 0; k < 16; k++)
      check($sformatf("d4 sample %0d", k), plog[0][k], {17'(-(1 + 4 * k)), 16'(1 + 4 * k)});
    check("d4 done pulses", ndone[0], 1);
    check("d4 overflow", dof[0], 1'b0);
    check("d4 idle after drain", db[0], 1'b0);

    // Table-driven: DECIM=1 with the consumer stalled, then released.
    rows[0] = '{1, 0,  1,  0, 1, 0, 0, 0};
    rows[1] = '{0, 0,  1,  1, 1, 0, 1, 1001};
    rows[2] = '{0, 0, 15, 16, 1, 0, 1, 1001};
    rows[3] = '{0, 0,  5, 16, 1, 0, 1, 1001};
    rows[4] = '{0, 1,  1, 15, 1, 0, 1, 1002};
    rows[5] = '{0, 1, 14,  1, 1, 0, 1, 1016};
    rows[6] = '{0, 1,  1,  0, 1, 0, 0, 0};
    rows[7] = '{0, 1,  1,  0, 0, 1, 0, 0};
    rows[8] = '{0, 1,  1,  0, 0, 0, 0, 0};
    reset_all();
    rdy = '0;
    begin
      int c;
      c = 0;
      for (int r = 0; r < 9; r++) begin
        arm_s[1] = rows[r].arm;
        rdy[1]   = rows[r].rdy;
        for (int n = 0; n < rows[r].n; n++) begin
          set_sine(1000 + c);
          tick();
          c++;
        end
        arm_s[1] = 1'b0;
        check($sformatf("stall row %0d", r),
              {9'(c1), db[1], dn[1], dv[1], (dv[1] ? dd[1][15:0] : 16'd0)},
              {9'(rows[r].e_count), rows[r].e_busy, rows[r].e_done, rows[r].e_valid, 16'(rows[r].e_sine)});
      end
    end

    // DEPTH=4: stalled consumer. A capture starts with an empty FIFO and writes
    // at most DEPTH slots, so no slot finds the FIFO full and overflow stays low.
    reset_all();
    rdy = '0;
    for (int c = 0; c < 12; c++) begin
      set_sine(2000 + c);
      arm_s[2] = (c == 0);
      tick();
    end
    arm_s = '0;
    check("d4x1 full count", c2, 3'd4);
    check("d4x1 held in drain", db[2], 1'b1);
    check("d4x1 head sample", dd[2][15:0], 16'd2001);
    check("d4x1 overflow", dof[2], 1'b0);
    rdy[2] = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    check("d4x1 drained", {c2, db[2]}, 4'd0);
    check("d4x1 done pulses", ndone[2], 1);
    arm_s[2] = 1'b1;
    tick();
    arm_s[2] = 1'b0;
    check("d4x1 rearm flags", {db[2], dof[2]}, 2'b10);
    for (int c = 0; c < 12; c++) tick();

    // Reset in the middle of CAPTURE, then a re-arm on the first edge after release.
    reset_all();
    rdy = '1;
    for (int c = 0; c < 25; c++) begin
      set_sine(c);
      arm_s[0] = (c == 0);
      tick();
    end
    arm_s = '0;
    check("mid reset pre-count", plen[0], 6);
    rst[0] = 1'b1;
    set_sine(25);
    tick();
    check("mid reset state", {dv[0], c0, db[0], dn[0], dof[0]}, 9'd0);
    rst[0] = 1'b0;
    clear_logs();
    for (int c = 0; c < 70; c++) begin
      set_sine(500 + c);
      arm_s[0] = (c == 0);
      tick();
    end
    arm_s = '0;
    check("rearm sample count", plen[0], 16);
    for (int k = 0; k < 16; k++)
      check($sformatf("rearm sample %0d", k), plog[0][k][15:0], 16'(501 + 4 * k));
    check("rearm done pulses", ndone[0], 1);

`ifdef DDFS_SAMPLE_TRIGGER_EN
    // Trigger on the rising zero crossing: -3, -1, 2, 5, ...
    reset_all();
    rdy = '0;
    set_sine(-3); arm_s[1] = 1'b1; tick(); arm_s[1] = 1'b0;
    check("trig busy at arm", db[1], 1'b1);
    set_sine(-1); tick();
    check("trig waiting", {db[1], c1}, {1'b1, 5'd0});
    set_sine(2); tick();
    check("trig first sample", {c1, dd[1][15:0]}, {5'd1, 16'd2});
    for (int c = 0; c < 20; c++) begin
      set_sine(5 + 3 * c);
      tick();
    end
    rdy = '1;
    for (int c = 0; c < 20; c++) tick();
`endif

    // Alternating ready during a DECIM=1 capture.
    reset_all();
    rdy = '0;
    for (int c = 0; c < 60; c++) begin
      set_sine(3000 + c);
      arm_s[1] = (c == 0);
      rdy[1]   = (c % 2 == 1);
      tick();
    end
    arm_s = '0;
    check("alt sample count", plen[1], 16);
    for (int k = 0; k < 16; k++)
      check($sformatf("alt sample %0d", k), plog[1][k][15:0], 16'(3001 + k));
    check("alt done pulses", ndone[1], 1);
    check("alt count bound", (maxc <= 16), 1'b1);

    // Randomized traffic against the model, with occasional resets.
    reset_all();
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NI; i++) begin
        rst[i]   = ($urandom_range(0, 299) == 0);
        arm_s[i] = ($urandom_range(0, 7) == 0);
        rdy[i]   = ($urandom_range(0, 3) != 0);
      end
      sine_v = 16'($urandom);
      tri_v  = 17'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
